// File: rtl/alu_core_pkg.sv
// -----------------------------------------------------------------------------
// alu_core_pkg
// Shared definitions for the accumulator-datapath ALU stage: operation codes
// (also used by the control unit and instruction decoder), FSM state encoding
// and the multiply iteration count.
// -----------------------------------------------------------------------------
package alu_core_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_MUL = 3'd7
    } aluop_e;

    typedef enum logic {
        ALU_S_IDLE = 1'b0,
        ALU_S_MUL  = 1'b1
    } alu_state_e;

    // One shift-add iteration per multiplier bit.
    localparam int ALU_MUL_ITERS = 16;

endpackage

// File: rtl/alu_mul16.sv
// -----------------------------------------------------------------------------
// alu_mul16
// Iterative unsigned shift-add multiplier, one multiplier bit per step.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   load_i         in   capture operands, clear product and counter
//   step_i         in   perform one shift-add iteration
//   mcand_i        in   multiplicand (zero-extended internally)
//   mplier_i       in   multiplier
//   product_next_o out  product value after the current iteration
//   last_o         out  high while the current iteration is the final one
// -----------------------------------------------------------------------------
module alu_mul16
    import alu_core_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] product_next_o,
    output logic               last_o
);

    localparam int CNT_W = $clog2(ALU_MUL_ITERS);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [CNT_W-1:0]   cnt_q;

    // Exposing the post-add value lets the core capture the final product on
    // the 16th edge itself instead of one cycle later.
    always_comb begin
        prod_d = prod_q;
        if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
        end
    end

    assign product_next_o = prod_d;
    assign last_o         = (cnt_q == CNT_W'(ALU_MUL_ITERS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Sequential ALU stage: one operation per start request, result held in a
// register. Single-cycle ops complete on the sampling edge; MUL runs 16
// iterations in alu_mul16 while busy is high.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   operation request, sampled only in IDLE
//   aluop   in   operation code, captured with start
//   a       in   operand A (accumulator)
//   b       in   operand B (B-operand mux)
//   result  out  registered result
//   zero    out  registered (result == 0)
//   ovf     out  overflow of the last completed operation
//   busy    out  multiply in progress
//   done    out  one-cycle pulse when result/zero/ovf update
// -----------------------------------------------------------------------------
module alu_core
    import alu_core_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    alu_state_e         state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               done_q;

    logic [WIDTH-1:0]   op_res_d;
    logic               op_ovf_d;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod_next;
    logic               mul_last;
    logic               mul_load;
    logic               is_mul;

    assign is_mul   = (aluop_e'(aluop) == ALU_MUL);
    assign mul_load = (state_q == ALU_S_IDLE) && start && is_mul;
    assign busy     = (state_q == ALU_S_MUL);

    alu_mul16 #(.WIDTH(WIDTH)) u_mul (
        .clk            (clk),
        .reset          (reset),
        .load_i         (mul_load),
        .step_i         (busy),
        .mcand_i        (a),
        .mplier_i       (b),
        .product_next_o (prod_next),
        .last_o         (mul_last)
    );

    assign sum  = a + b;
    assign diff = a - b;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        op_res_d = '0;
        op_ovf_d = 1'b0;
        unique case (aluop_e'(aluop))
            ALU_ADD: begin
                op_res_d = sum;
                // Same-sign operands producing an opposite-sign sum.
                op_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                op_res_d = diff;
                // Opposite-sign operands where the difference takes b's sign.
                op_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: op_res_d = a & b;
            ALU_OR:  op_res_d = a | b;
            ALU_SLT: op_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: op_res_d = a << b[3:0];
            ALU_SRL: op_res_d = a >> b[3:0];
            ALU_MUL: op_res_d = '0;
            default: op_res_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ALU_S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ALU_S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state_q <= ALU_S_MUL;
                        end else begin
                            result_q <= op_res_d;
                            zero_q   <= (op_res_d == '0);
                            ovf_q    <= op_ovf_d;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ALU_S_MUL: begin
                    // start is ignored here; outputs hold until the last step.
                    if (mul_last) begin
                        result_q <= prod_next[WIDTH-1:0];
                        zero_q   <= (prod_next[WIDTH-1:0] == '0);
                        ovf_q    <= |prod_next[2*WIDTH-1:WIDTH];
                        done_q   <= 1'b1;
                        state_q  <= ALU_S_IDLE;
                    end
                end
                default: state_q <= ALU_S_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core
// Self-checking bench for alu_core: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_core;
    import alu_core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  aluop;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        zero;
    logic        ovf;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_core #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .aluop  (aluop),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic void model(input logic [2:0] op, input logic [15:0] x,
                                  input logic [15:0] y,
                                  output logic [15:0] r, output logic o);
        int     sx, sy, s;
        longint p;
        int     sh;
        logic [31:0] w;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sh = int'(y % 16);
        r  = 16'h0;
        o  = 1'b0;
        case (op)
            3'd0: begin s = sx + sy; w = s; r = w[15:0]; o = (s > 32767) || (s < -32768); end
            3'd1: begin s = sx - sy; w = s; r = w[15:0]; o = (s > 32767) || (s < -32768); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = (sx < sy) ? 16'd1 : 16'd0;
            3'd5: begin w = (32'(x) * (32'd1 << sh)) % 32'h10000; r = w[15:0]; end
            3'd6: begin w = 32'(x) / (32'd1 << sh); r = w[15:0]; end
            default: begin
                p = longint'(x) * longint'(y);
                r = 16'(p % 65536);
                o = (p >= 65536);
            end
        endcase
    endfunction

    // Issue one op; for MUL optionally inject an ignored ADD request mid-run.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] x, input logic [15:0] y,
                          input bit inject);
        logic [15:0] er;
        logic        eo;
        int          busy_cnt;
        int          done_cnt;
        model(op, x, y, er, eo);
        @(negedge clk);
        start = 1'b1; aluop = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        if (op != 3'd7) begin
            check({tag, "_done"}, 32'(done), 32'd1);
        end else begin
            busy_cnt = 0;
            done_cnt = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) break;
                if (busy) busy_cnt++;
                if (inject && i == 5) begin
                    start = 1'b1; aluop = 3'd0; a = 16'd1; b = 16'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_zero"}, 32'(zero), 32'(er == 16'h0));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        if (op == 3'd7) begin
            // Single pulse from a multiply, and no extra completion from the
            // injected request.
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (done) done_cnt++;
            end
            check({tag, "_no_extra_done"}, 32'(done_cnt), 32'd0);
            check({tag, "_result_hold"}, 32'(result), 32'(er));
        end
    endtask

    initial begin
        logic [15:0] rx, ry;
        logic [2:0]  rop;
        int          guard;

        reset = 1'b1; start = 1'b0; aluop = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed corners
        run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0);
        run_op("sub_zero", 3'd1, 16'h0005, 16'h0005, 1'b0);
        run_op("sub_ovf", 3'd1, 16'h8000, 16'h0001, 1'b0);
        run_op("slt_neg", 3'd4, 16'hFFFF, 16'h0002, 1'b0);
        run_op("sll_3", 3'd5, 16'h0001, 16'h0013, 1'b0);
        run_op("sll_0", 3'd5, 16'hABCD, 16'h0010, 1'b0);
        run_op("srl_15", 3'd6, 16'h8000, 16'h000F, 1'b0);
        run_op("and", 3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
        run_op("or", 3'd3, 16'hF000, 16'h000F, 1'b0);
        run_op("mul_300", 3'd7, 16'd300, 16'd300, 1'b1);
        run_op("mul_ffff", 3'd7, 16'h00FF, 16'h0101, 1'b0);
        run_op("mul_b0", 3'd7, 16'h1234, 16'h0000, 1'b0);

        // Reset partway through a multiply
        @(negedge clk);
        start = 1'b1; aluop = 3'd7; a = 16'h1234; b = 16'h0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        check("rstmul_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmul_busy", 32'(busy), 32'd0);
        check("rstmul_done", 32'(done), 32'd0);
        check("rstmul_result", 32'(result), 32'd0);
        check("rstmul_zero", 32'(zero), 32'd1);
        repeat (20) begin
            @(posedge clk); #1;
            if (done) check("rstmul_late_done", 32'(done), 32'd0);
        end
        run_op("add_after_rst", 3'd0, 16'd2, 16'd2, 1'b0);

        // start held high: MUL, then ADD in the done cycle, then AND
        @(negedge clk);
        start = 1'b1; aluop = 3'd7; a = 16'd300; b = 16'd300;
        @(posedge clk); #1;
        guard = 0;
        while (!done && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("held_mul_done", 32'(done), 32'd1);
        check("held_mul_result", 32'(result), 32'h5F90);
        aluop = 3'd0; a = 16'h0010; b = 16'h0020;
        @(posedge clk); #1;
        check("held_add_done", 32'(done), 32'd1);
        check("held_add_result", 32'(result), 32'h0030);
        aluop = 3'd2; a = 16'hF0F0; b = 16'h0FF0;
        @(posedge clk); #1;
        check("held_and_done", 32'(done), 32'd1);
        check("held_and_result", 32'(result), 32'h00F0);
        start = 1'b0;
        @(posedge clk); #1;
        check("held_done_drop", 32'(done), 32'd0);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            case ($urandom_range(0, 5))
                0: rx = 16'h7FFF;
                1: ry = 16'h8000;
                2: ry = 16'h0000;
                default: ;
            endcase
            run_op("rand", rop, rx, ry, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
